// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO between a UART receiver and a register block.
//
// Ports
//   iClk      single clock for all logic
//   iRstN     asynchronous active-low reset; release is synchronised to iClk
//   iData     received byte, qualified by iValid
//   iValid    one-cycle push strobe
//   iTaken    one-cycle pop strobe
//   iFlush    synchronous clear of FIFO contents (overrides push/pop)
//   iClrErr   clears the sticky overrun flag
//   oData     byte at FIFO head (first-word-fall-through), 0 while empty
//   oValid    FIFO non-empty
//   oLevel    fill count, 0..DEPTH
//   oTrigger  oLevel >= TRIGGER
//   oTimeout  FIFO non-empty and idle for TIMEOUT cycles
//   oOverrun  sticky: a byte was dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int DEPTH   = 16,
    parameter int TRIGGER = 8,
    parameter int TIMEOUT = 14000
) (
    input  logic                       iClk,
    input  logic                       iRstN,
    input  logic [7:0]                 iData,
    input  logic                       iValid,
    output logic [7:0]                 oData,
    output logic                       oValid,
    input  logic                       iTaken,
    input  logic                       iFlush,
    input  logic                       iClrErr,
    output logic [$clog2(DEPTH):0]     oLevel,
    output logic                       oTrigger,
    output logic                       oTimeout,
    output logic                       oOverrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count, countNext;
    logic [IW-1:0] idleCnt, idleNext;
    logic [1:0]    rstSync;
    logic          ready, full, push, pop, overflow, overrun;

    // Two-stage release synchroniser; strobes are ignored until it has filled.
    always_ff @(posedge iClk or negedge iRstN)
        if (!iRstN) rstSync <= '0;
        else        rstSync <= {rstSync[0], 1'b1};

    always_comb begin
        ready     = rstSync[1];
        full      = count == CW'(DEPTH);
        pop       = ready && iTaken && count != '0;
        // A full FIFO still accepts a byte when a pop frees a slot the same cycle.
        push      = ready && iValid && (!full || pop);
        overflow  = ready && iValid && !push && !iFlush;
        countNext = iFlush ? '0 : count + CW'(push) - CW'(pop);
        idleNext  = (iFlush || push || pop || count == '0) ? '0 :
                    (idleCnt == IW'(TIMEOUT)) ? idleCnt : idleCnt + IW'(1);
    end

    always_ff @(posedge iClk or negedge iRstN)
        if (!iRstN) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            idleCnt <= '0;
            overrun <= 1'b0;
        end else begin
            if (iFlush) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + AW'(1);
                if (pop)  rdPtr <= rdPtr + AW'(1);
            end
            count   <= countNext;
            idleCnt <= idleNext;
            // A fresh overrun wins over a same-cycle clear.
            overrun <= overflow || (overrun && !iClrErr);
        end

    always_ff @(posedge iClk)
        if (push && !iFlush) mem[wrPtr] <= iData;

    always_comb begin
        oValid   = count != '0;
        oData    = oValid ? mem[rdPtr] : 8'h00;
        oLevel   = count;
        oTrigger = count >= CW'(TRIGGER);
        oTimeout = oValid && idleCnt == IW'(TIMEOUT);
        oOverrun = overrun;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DEPTH=16, TRIGGER=8, TIMEOUT=100).
module tb_uart_rx_fifo;
    logic       iClk = 1'b0;
    logic       iRstN = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iValid = 1'b0;
    logic       iTaken = 1'b0;
    logic       iFlush = 1'b0;
    logic       iClrErr = 1'b0;
    logic [7:0] oData;
    logic       oValid;
    logic [4:0] oLevel;
    logic       oTrigger;
    logic       oTimeout;
    logic       oOverrun;
    int         passed = 0;
    int         total = 0;

    uart_rx_fifo #(.DEPTH(16), .TRIGGER(8), .TIMEOUT(100)) dut (
        .iClk(iClk), .iRstN(iRstN), .iData(iData), .iValid(iValid), .oData(oData),
        .oValid(oValid), .iTaken(iTaken), .iFlush(iFlush), .iClrErr(iClrErr),
        .oLevel(oLevel), .oTrigger(oTrigger), .oTimeout(oTimeout), .oOverrun(oOverrun)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        iData = b;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
    endtask

    task automatic pop();
        iTaken = 1'b1;
        tick();
        iTaken = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", int'(oValid), 0);
        chk("rst_level", int'(oLevel), 0);
        chk("rst_trigger", int'(oTrigger), 0);
        chk("rst_timeout", int'(oTimeout), 0);
        chk("rst_overrun", int'(oOverrun), 0);
        iRstN = 1'b1;
        repeat (3) tick();

        push(8'h41); push(8'h42); push(8'h43);
        chk("abc_level", int'(oLevel), 3);
        chk("abc_head", int'(oData), 'h41);
        chk("abc_valid", int'(oValid), 1);
        pop();
        chk("abc_pop1", int'(oData), 'h42);
        pop();
        chk("abc_pop2", int'(oData), 'h43);
        chk("abc_level1", int'(oLevel), 1);
        pop();
        chk("abc_empty_valid", int'(oValid), 0);
        chk("abc_empty_level", int'(oLevel), 0);
        pop();
        chk("pop_empty_level", int'(oLevel), 0);
        chk("pop_empty_valid", int'(oValid), 0);

        for (int i = 1; i <= 7; i++) push(8'(i));
        chk("trig7_level", int'(oLevel), 7);
        chk("trig7", int'(oTrigger), 0);
        push(8'h08);
        chk("trig8", int'(oTrigger), 1);
        pop();
        chk("trig_pop", int'(oTrigger), 0);
        chk("trig_pop_level", int'(oLevel), 7);
        iFlush = 1'b1; iValid = 1'b1; iData = 8'h99;
        tick();
        iFlush = 1'b0; iValid = 1'b0;
        chk("flush_level", int'(oLevel), 0);
        chk("flush_valid", int'(oValid), 0);

        for (int i = 0; i <= 16; i++) push(8'(i));
        chk("ovr_level", int'(oLevel), 16);
        chk("ovr_flag", int'(oOverrun), 1);
        chk("ovr_head", int'(oData), 0);
        for (int i = 0; i < 16; i++) begin
            chk("ovr_order", int'(oData), i);
            pop();
        end
        chk("ovr_drained", int'(oValid), 0);
        chk("ovr_still_set", int'(oOverrun), 1);
        iClrErr = 1'b1;
        tick();
        iClrErr = 1'b0;
        chk("ovr_cleared", int'(oOverrun), 0);

        for (int i = 0; i < 16; i++) push(8'(i));
        iValid = 1'b1; iData = 8'hAA; iTaken = 1'b1;
        tick();
        iValid = 1'b0; iTaken = 1'b0;
        chk("pp_full_level", int'(oLevel), 16);
        chk("pp_full_head", int'(oData), 1);
        chk("pp_full_ovr", int'(oOverrun), 0);
        iValid = 1'b1; iData = 8'hBB; iClrErr = 1'b1;
        tick();
        iValid = 1'b0; iClrErr = 1'b0;
        chk("ovr_beats_clr", int'(oOverrun), 1);
        chk("ovr_beats_clr_level", int'(oLevel), 16);
        iClrErr = 1'b1;
        tick();
        iClrErr = 1'b0;
        chk("clr_after", int'(oOverrun), 0);
        repeat (15) pop();
        chk("pp_aa_head", int'(oData), 'hAA);
        chk("pp_aa_level", int'(oLevel), 1);
        pop();
        chk("pp_empty", int'(oLevel), 0);
        iValid = 1'b1; iData = 8'h5A; iTaken = 1'b1;
        tick();
        iValid = 1'b0; iTaken = 1'b0;
        chk("pp_zero_level", int'(oLevel), 1);
        chk("pp_zero_head", int'(oData), 'h5A);

        chk("to_start", int'(oTimeout), 0);
        repeat (99) tick();
        chk("to_99", int'(oTimeout), 0);
        tick();
        chk("to_100", int'(oTimeout), 1);
        repeat (5) tick();
        chk("to_hold", int'(oTimeout), 1);
        pop();
        chk("to_pop", int'(oTimeout), 0);
        chk("to_pop_valid", int'(oValid), 0);

        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        chk("ar_level5", int'(oLevel), 5);
        #2;
        iRstN = 1'b0;
        #1;
        chk("ar_valid", int'(oValid), 0);
        chk("ar_level", int'(oLevel), 0);
        chk("ar_data", int'(oData), 0);
        chk("ar_trigger", int'(oTrigger), 0);
        chk("ar_timeout", int'(oTimeout), 0);
        chk("ar_overrun", int'(oOverrun), 0);
        tick();
        iRstN = 1'b1; iValid = 1'b1; iData = 8'h77;
        tick();
        iValid = 1'b0;
        chk("release_reject", int'(oLevel), 0);
        repeat (2) tick();
        push(8'h55);
        chk("ar_push_data", int'(oData), 'h55);
        chk("ar_push_level", int'(oLevel), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uartRxFifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, 2..256.
REQ-002 Parameter TRIGGER, default 8, fill level (1..DEPTH) at which oTrigger asserts.
REQ-003 Parameter TIMEOUT, default 14000, idle clock cycles before oTimeout asserts (about 4 characters at 115200 baud, 40 MHz).
REQ-004 iClk  input  1  single clock for all logic.
REQ-005 iRstN  input  1  reset; asynchronous and active-low.
REQ-006 iData  input  8  received byte from the serial receiver.
REQ-007 iValid  input  1  one-cycle push strobe qualifying iData.
REQ-008 oData  output  8  byte at FIFO head; first-word-fall-through.
REQ-009 oValid  output  1  FIFO non-empty; oData is meaningful.
REQ-010 iTaken  input  1  one-cycle pop strobe from the register block.
REQ-011 iFlush  input  1  synchronous clear of FIFO contents.
REQ-012 iClrErr  input  1  clears oOverrun.
REQ-013 oLevel  output  log2(DEPTH)+1  current fill count, 0..DEPTH.
REQ-014 oTrigger  output  1  oLevel >= TRIGGER.
REQ-015 oTimeout  output  1  FIFO non-empty and idle for TIMEOUT cycles.
REQ-016 oOverrun  output  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-017 Storage SHALL be a circular buffer with write and read pointers plus a count register; pointers wrap from DEPTH-1 to 0.
REQ-018 Push accepted when iValid=1 and (count<DEPTH or a pop occurs the same cycle); byte written at wrPtr, wrPtr+1.
REQ-019 Pop when iTaken=1 and count>0: rdPtr+1; iTaken while empty SHALL be ignored with no state change.
REQ-020 Simultaneous push and pop with count in 1..DEPTH: both performed, count unchanged; at count=0 the push only is performed, count becomes 1.
REQ-021 Push while full without a same-cycle pop: byte discarded, FIFO unchanged, oOverrun set to 1 the next cycle.
REQ-022 oOverrun stays 1 until the cycle after iClrErr=1; a new overrun in the same cycle as iClrErr wins, so oOverrun remains 1.
REQ-023 oData SHALL equal mem[rdPtr] combinationally; a byte pushed into an empty FIFO appears on oData with oValid=1 one cycle after the push strobe.
REQ-024 oLevel, oValid and oTrigger SHALL reflect the registered count, updating one cycle after the push/pop strobe.
REQ-025 Idle counter: cleared to 0 on any accepted push, any pop, flush, or when count=0; otherwise increments by 1 per cycle, saturating at TIMEOUT.
REQ-026 oTimeout=1 exactly when idle counter = TIMEOUT and count>0; deasserts the cycle after the next push, pop or flush.
REQ-027 iFlush=1: next cycle count=0, both pointers=0, idle counter=0; flush overrides a same-cycle push or pop; oOverrun unaffected.
REQ-028 No combinational path from iValid/iData to any output; iTaken affects outputs only after a clock edge.

Reset
REQ-029 iRstN=0 SHALL asynchronously force pointers=0, count=0, idle counter=0, oValid=0, oLevel=0, oTrigger=0, oTimeout=0, oOverrun=0; memory contents undefined and never presented (oValid=0).
REQ-030 Reset asserted mid-operation discards all stored bytes; the first push after release reads back as the head byte.
REQ-031 Deassertion SHALL be synchronised internally to iClk; no push or pop is accepted in the release cycle.

Verification
REQ-032 Push 0x41,0x42,0x43 on consecutive cycles -> oLevel=3, oData=0x41; three pops -> oData 0x42, 0x43, then oValid=0, oLevel=0.
REQ-033 Push 17 bytes 0x00..0x10 with DEPTH=16, no pops -> oLevel=16, oOverrun=1, byte 0x10 lost; 16 pops return 0x00..0x0F in order; iClrErr -> oOverrun=0.
REQ-034 Fill to 16, then simultaneous push 0xAA and pop -> oLevel stays 16; after 15 further pops the head byte is 0xAA; with count=0, simultaneous push/pop -> oLevel=1.
REQ-035 TIMEOUT=100: push one byte and stay idle -> oTimeout rises exactly 100 cycles after the level update and stays high; one pop -> oTimeout=0 next cycle, oValid=0.
REQ-036 TRIGGER=8: 7 pushes -> oTrigger=0; 8th push -> oTrigger=1; one pop -> 0; iFlush with a same-cycle push -> oLevel=0, oValid=0.
REQ-037 Assert iRstN=0 asynchronously mid-burst with 5 bytes stored -> all outputs 0 immediately without a clock edge; after release, push 0x55 -> oData=0x55, oLevel=1.
